l1_meta_array: RTL and testbench

- Storage endpoint for L1 data-cache metadata (coherence state plus tag per set/way).
- Its write port consumes the output of the two-input priority meta-write arbiter: write requests carry idx, way_en, coh_state and tag.
- Its read port serves the dcache pipeline's tag lookup and returns all ways of a set one cycle later.
- On reset it runs a self-clearing sweep so every line starts in coherence state Nothing (0).

---
 rtl/l1_meta_array.sv | 128 ++++++++++++
 tb/tb_l1_meta_array.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l1_meta_array.sv
// L1 data-cache metadata array: coherence state plus tag for every set/way.
// A clear sweep zeroes every set after reset; after that the array serves one
// read or one write per cycle, with reads taking priority over writes.
module l1_meta_array #(
  parameter  int N_SETS   = 64,
  parameter  int N_WAYS   = 8,
  parameter  int TAG_BITS = 21,
  parameter  int COH_BITS = 2,
  localparam int IDX_BITS = $clog2(N_SETS)
) (
  input  logic                         clock,
  input  logic                         reset,
  output logic                         io_write_ready,
  input  logic                         io_write_valid,
  input  logic [IDX_BITS-1:0]          io_write_bits_idx,
  input  logic [N_WAYS-1:0]            io_write_bits_way_en,
  input  logic [COH_BITS-1:0]          io_write_bits_data_coh_state,
  input  logic [TAG_BITS-1:0]          io_write_bits_data_tag,
  output logic                         io_read_ready,
  input  logic                         io_read_valid,
  input  logic [IDX_BITS-1:0]          io_read_bits_idx,
  output logic                         io_resp_valid,
  output logic [N_WAYS*COH_BITS-1:0]   io_resp_bits_coh_state,
  output logic [N_WAYS*TAG_BITS-1:0]   io_resp_bits_tag,
  output logic                         io_init_done
);

  typedef enum logic {INIT, RUN} state_t;

  state_t               state;
  state_t               state_next;
  logic [IDX_BITS-1:0]  clear_cnt;
  logic                 sweep_en;
  logic                 write_fire;
  logic                 read_fire;
  logic [IDX_BITS-1:0]  wr_idx;
  logic [N_WAYS-1:0]    wr_mask;
  logic [COH_BITS-1:0]  wr_coh;
  logic [TAG_BITS-1:0]  wr_tag;

  // State register: reset always returns to the clear sweep
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= INIT;
    else        state <= state_next;
  end

  // Next state: leave INIT once the last set has been cleared
  always_comb begin
    state_next = state;
    if (state == INIT && clear_cnt == IDX_BITS'(N_SETS - 1)) state_next = RUN;
  end

  // Outputs: ports are closed during the sweep; a read stalls any write
  always_comb begin
    sweep_en       = 1'b0;
    io_init_done   = 1'b0;
    io_read_ready  = 1'b0;
    io_write_ready = 1'b0;
    case (state)
      INIT: sweep_en = 1'b1;
      RUN: begin
        io_init_done   = 1'b1;
        io_read_ready  = 1'b1;
        io_write_ready = ~io_read_valid;
      end
      default: ;
    endcase
  end

  // Clear counter walks the sets once per cycle while sweeping
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)        clear_cnt <= '0;
    else if (sweep_en) clear_cnt <= clear_cnt + IDX_BITS'(1);
  end

  assign write_fire = io_write_valid & io_write_ready;
  assign read_fire  = io_read_valid & io_read_ready;

  // Storage write port is shared between the clear sweep and client writes
  always_comb begin
    wr_idx  = io_write_bits_idx;
    wr_mask = write_fire ? io_write_bits_way_en : '0;
    wr_coh  = io_write_bits_data_coh_state;
    wr_tag  = io_write_bits_data_tag;
    if (sweep_en) begin
      wr_idx  = clear_cnt;
      wr_mask = '1;
      wr_coh  = '0;
      wr_tag  = '0;
    end
  end

  // Response valid follows a read fire by exactly one cycle
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) io_resp_valid <= 1'b0;
    else        io_resp_valid <= read_fire;
  end

  for (genvar w = 0; w < N_WAYS; w++) begin : g_way
    logic [COH_BITS-1:0] coh_mem [N_SETS];
    logic [TAG_BITS-1:0] tag_mem [N_SETS];
    logic [COH_BITS-1:0] resp_coh;
    logic [TAG_BITS-1:0] resp_tag;

    // Per-way storage, written when this way is selected
    always_ff @(posedge clock) begin
      if (wr_mask[w]) begin
        coh_mem[wr_idx] <= wr_coh;
        tag_mem[wr_idx] <= wr_tag;
      end
    end

    // Per-way response register, holds its value between reads
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        resp_coh <= '0;
        resp_tag <= '0;
      end else if (read_fire) begin
        resp_coh <= coh_mem[io_read_bits_idx];
        resp_tag <= tag_mem[io_read_bits_idx];
      end
    end

    assign io_resp_bits_coh_state[w*COH_BITS +: COH_BITS] = resp_coh;
    assign io_resp_bits_tag[w*TAG_BITS +: TAG_BITS]       = resp_tag;
  end

endmodule

// File: tb/tb_l1_meta_array.sv
// Testbench for l1_meta_array: directed scenarios plus randomized traffic
// compared against a set/way array model of the metadata store.
module tb_l1_meta_array;

  logic         clock;
  logic         reset;
  logic         io_write_ready;
  logic         io_write_valid;
  logic [5:0]   io_write_bits_idx;
  logic [7:0]   io_write_bits_way_en;
  logic [1:0]   io_write_bits_data_coh_state;
  logic [20:0]  io_write_bits_data_tag;
  logic         io_read_ready;
  logic         io_read_valid;
  logic [5:0]   io_read_bits_idx;
  logic         io_resp_valid;
  logic [15:0]  io_resp_bits_coh_state;
  logic [167:0] io_resp_bits_tag;
  logic         io_init_done;

  int checks = 0;
  int errors = 0;

  logic [1:0]  m_coh [64][8];
  logic [20:0] m_tag [64][8];

  l1_meta_array dut (
    .clock                        (clock),
    .reset                        (reset),
    .io_write_ready               (io_write_ready),
    .io_write_valid               (io_write_valid),
    .io_write_bits_idx            (io_write_bits_idx),
    .io_write_bits_way_en         (io_write_bits_way_en),
    .io_write_bits_data_coh_state (io_write_bits_data_coh_state),
    .io_write_bits_data_tag       (io_write_bits_data_tag),
    .io_read_ready                (io_read_ready),
    .io_read_valid                (io_read_valid),
    .io_read_bits_idx             (io_read_bits_idx),
    .io_resp_valid                (io_resp_valid),
    .io_resp_bits_coh_state       (io_resp_bits_coh_state),
    .io_resp_bits_tag             (io_resp_bits_tag),
    .io_init_done                 (io_init_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [15:0] exp_coh(int idx);
    logic [15:0] r;
    for (int w = 0; w < 8; w++) r[w*2 +: 2] = m_coh[idx][w];
    return r;
  endfunction

  function automatic logic [167:0] exp_tag(int idx);
    logic [167:0] r;
    for (int w = 0; w < 8; w++) r[w*21 +: 21] = m_tag[idx][w];
    return r;
  endfunction

  task automatic model_clear();
    for (int s = 0; s < 64; s++)
      for (int w = 0; w < 8; w++) begin
        m_coh[s][w] = 2'd0;
        m_tag[s][w] = 21'd0;
      end
  endtask

  task automatic model_write(int idx, logic [7:0] mask, logic [1:0] c, logic [20:0] t);
    for (int w = 0; w < 8; w++)
      if (mask[w]) begin
        m_coh[idx][w] = c;
        m_tag[idx][w] = t;
      end
  endtask

  // One-cycle write with no competing read; returns at the next negedge
  task automatic do_write(int idx, logic [7:0] mask, logic [1:0] c, logic [20:0] t);
    io_read_valid                = 1'b0;
    io_write_valid               = 1'b1;
    io_write_bits_idx            = 6'(idx);
    io_write_bits_way_en         = mask;
    io_write_bits_data_coh_state = c;
    io_write_bits_data_tag       = t;
    @(negedge clock);
    io_write_valid = 1'b0;
    model_write(idx, mask, c, t);
  endtask

  // One-cycle read; returns at the negedge where the response is visible
  task automatic do_read(int idx);
    io_read_valid    = 1'b1;
    io_read_bits_idx = 6'(idx);
    @(negedge clock);
    io_read_valid = 1'b0;
  endtask

  // Called right after reset release; counts edges until init_done rises
  task automatic wait_init(output int cycles, output logic bad_ready);
    logic done;
    cycles    = 0;
    done      = 1'b0;
    bad_ready = 1'b0;
    io_write_valid               = 1'b1;
    io_write_bits_idx            = 6'($urandom_range(0, 63));
    io_write_bits_way_en         = 8'hFF;
    io_write_bits_data_coh_state = 2'd3;
    io_write_bits_data_tag       = 21'h1FFFFF;
    while (!done && cycles < 200) begin
      @(posedge clock);
      #1;
      cycles++;
      if (io_init_done) done = 1'b1;
      else if (io_read_ready || io_write_ready) bad_ready = 1'b1;
    end
    io_write_valid = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_reset();
    int cycles;
    logic bad;
    reset = 1'b0;
    repeat (3) @(negedge clock);
    checks++; if (io_resp_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_resp_valid: got %0b exp 0", io_resp_valid); end
    checks++; if (io_init_done !== 1'b0) begin errors++; $display("[TB] FAIL reset_init_done: got %0b exp 0", io_init_done); end
    checks++; if (io_read_ready !== 1'b0 || io_write_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready: got rd=%0b wr=%0b exp 0/0", io_read_ready, io_write_ready); end
    checks++; if (io_resp_bits_coh_state !== 16'd0 || io_resp_bits_tag !== 168'd0) begin errors++; $display("[TB] FAIL reset_resp_bus: got coh=%h tag=%h exp 0", io_resp_bits_coh_state, io_resp_bits_tag); end
    reset = 1'b1;
    wait_init(cycles, bad);
    checks++; if (cycles != 64) begin errors++; $display("[TB] FAIL init_cycles: got %0d exp 64", cycles); end
    checks++; if (bad !== 1'b0) begin errors++; $display("[TB] FAIL init_ready_early: got %0b exp 0", bad); end
    model_clear();
    for (int s = 0; s < 64; s++) begin
      do_read(s);
      checks++; if (io_resp_valid !== 1'b1) begin errors++; $display("[TB] FAIL init_read_valid set %0d: got %0b exp 1", s, io_resp_valid); end
      checks++; if (io_resp_bits_coh_state !== exp_coh(s) || io_resp_bits_tag !== exp_tag(s)) begin errors++; $display("[TB] FAIL init_read_data set %0d: got coh=%h tag=%h exp coh=%h tag=%h", s, io_resp_bits_coh_state, io_resp_bits_tag, exp_coh(s), exp_tag(s)); end
    end
  endtask

  task automatic test_single_write();
    do_write(5, 8'h04, 2'd3, 21'h1ABCDE);
    checks++; if (io_resp_valid !== 1'b0) begin errors++; $display("[TB] FAIL single_rv_before: got %0b exp 0", io_resp_valid); end
    do_read(5);
    checks++; if (io_resp_valid !== 1'b1) begin errors++; $display("[TB] FAIL single_rv: got %0b exp 1", io_resp_valid); end
    checks++; if (io_resp_bits_coh_state !== exp_coh(5) || io_resp_bits_tag !== exp_tag(5)) begin errors++; $display("[TB] FAIL single_data: got coh=%h tag=%h exp coh=%h tag=%h", io_resp_bits_coh_state, io_resp_bits_tag, exp_coh(5), exp_tag(5)); end
    checks++; if (io_resp_bits_tag[62:42] !== 21'h1ABCDE || io_resp_bits_coh_state[5:4] !== 2'd3) begin errors++; $display("[TB] FAIL single_way2: got coh=%0d tag=%h exp 3/1abcde", io_resp_bits_coh_state[5:4], io_resp_bits_tag[62:42]); end
    @(negedge clock);
    checks++; if (io_resp_valid !== 1'b0) begin errors++; $display("[TB] FAIL single_rv_after: got %0b exp 0", io_resp_valid); end
  endtask

  task automatic test_collision();
    logic [15:0]  ec;
    logic [167:0] et;
    io_read_valid                = 1'b1;
    io_read_bits_idx             = 6'd5;
    io_write_valid               = 1'b1;
    io_write_bits_idx            = 6'd5;
    io_write_bits_way_en         = 8'h01;
    io_write_bits_data_coh_state = 2'd1;
    io_write_bits_data_tag       = 21'h7;
    #1;
    checks++; if (io_write_ready !== 1'b0 || io_read_ready !== 1'b1) begin errors++; $display("[TB] FAIL coll_ready: got rd=%0b wr=%0b exp 1/0", io_read_ready, io_write_ready); end
    ec = exp_coh(5);
    et = exp_tag(5);
    @(negedge clock);
    io_read_valid = 1'b0;
    checks++; if (io_resp_valid !== 1'b1 || io_resp_bits_coh_state !== ec || io_resp_bits_tag !== et) begin errors++; $display("[TB] FAIL coll_old_data: got v=%0b coh=%h tag=%h exp v=1 coh=%h tag=%h", io_resp_valid, io_resp_bits_coh_state, io_resp_bits_tag, ec, et); end
    #1;
    checks++; if (io_write_ready !== 1'b1) begin errors++; $display("[TB] FAIL coll_write_ready: got %0b exp 1", io_write_ready); end
    @(negedge clock);
    io_write_valid = 1'b0;
    model_write(5, 8'h01, 2'd1, 21'h7);
    do_read(5);
    checks++; if (io_resp_bits_coh_state !== exp_coh(5) || io_resp_bits_tag !== exp_tag(5)) begin errors++; $display("[TB] FAIL coll_new_data: got coh=%h tag=%h exp coh=%h tag=%h", io_resp_bits_coh_state, io_resp_bits_tag, exp_coh(5), exp_tag(5)); end
    checks++; if (io_resp_bits_coh_state[1:0] !== 2'd1 || io_resp_bits_tag[20:0] !== 21'h7) begin errors++; $display("[TB] FAIL coll_way0: got coh=%0d tag=%h exp 1/7", io_resp_bits_coh_state[1:0], io_resp_bits_tag[20:0]); end
  endtask

  task automatic test_masks();
    do_write(63, 8'hFF, 2'd2, 21'h155555);
    do_read(63);
    checks++; if (io_resp_bits_coh_state !== 16'hAAAA || io_resp_bits_tag !== {8{21'h155555}}) begin errors++; $display("[TB] FAIL mask_all: got coh=%h tag=%h exp coh=aaaa tag=8x155555", io_resp_bits_coh_state, io_resp_bits_tag); end
    do_write(63, 8'h00, 2'd1, 21'h0ABCDE);
    do_read(63);
    checks++; if (io_resp_bits_coh_state !== exp_coh(63) || io_resp_bits_tag !== exp_tag(63)) begin errors++; $display("[TB] FAIL mask_zero: got coh=%h tag=%h exp coh=%h tag=%h", io_resp_bits_coh_state, io_resp_bits_tag, exp_coh(63), exp_tag(63)); end
  endtask

  task automatic test_back_to_back();
    for (int i = 1; i <= 3; i++)
      do_write(i, 8'h80, 2'($urandom_range(1, 3)), 21'($urandom));
    for (int k = 0; k < 4; k++) begin
      io_read_valid    = (k < 3);
      io_read_bits_idx = 6'(k + 1);
      @(negedge clock);
      if (k < 3) begin
        checks++; if (io_resp_valid !== 1'b1 || io_resp_bits_coh_state !== exp_coh(k + 1) || io_resp_bits_tag !== exp_tag(k + 1)) begin errors++; $display("[TB] FAIL b2b_resp %0d: got v=%0b coh=%h tag=%h exp v=1 coh=%h tag=%h", k + 1, io_resp_valid, io_resp_bits_coh_state, io_resp_bits_tag, exp_coh(k + 1), exp_tag(k + 1)); end
      end else begin
        checks++; if (io_resp_valid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_rv_end: got %0b exp 0", io_resp_valid); end
      end
    end
  endtask

  task automatic test_random();
    logic         wpend;
    logic         rv;
    logic         exp_rv;
    logic [15:0]  ec;
    logic [167:0] et;
    wpend  = 1'b0;
    exp_rv = 1'b0;
    ec     = '0;
    et     = '0;
    for (int n = 0; n < 400; n++) begin
      checks++; if (io_resp_valid !== exp_rv) begin errors++; $display("[TB] FAIL rand_rv cyc %0d: got %0b exp %0b", n, io_resp_valid, exp_rv); end
      if (exp_rv) begin
        checks++; if (io_resp_bits_coh_state !== ec || io_resp_bits_tag !== et) begin errors++; $display("[TB] FAIL rand_data cyc %0d: got coh=%h tag=%h exp coh=%h tag=%h", n, io_resp_bits_coh_state, io_resp_bits_tag, ec, et); end
      end
      rv = ($urandom_range(0, 2) == 0);
      if (!wpend && $urandom_range(0, 1) == 1) begin
        wpend                        = 1'b1;
        io_write_bits_idx            = 6'($urandom_range(0, 7));
        io_write_bits_way_en         = 8'($urandom_range(0, 255));
        io_write_bits_data_coh_state = 2'($urandom);
        io_write_bits_data_tag       = 21'($urandom);
      end
      io_write_valid   = wpend;
      io_read_valid    = rv;
      io_read_bits_idx = 6'($urandom_range(0, 7));
      #1;
      checks++; if (io_write_ready !== !rv || io_read_ready !== 1'b1) begin errors++; $display("[TB] FAIL rand_ready cyc %0d: got rd=%0b wr=%0b exp 1/%0b", n, io_read_ready, io_write_ready, !rv); end
      exp_rv = rv;
      if (rv) begin
        ec = exp_coh(int'(io_read_bits_idx));
        et = exp_tag(int'(io_read_bits_idx));
      end
      if (wpend && !rv) begin
        model_write(int'(io_write_bits_idx), io_write_bits_way_en, io_write_bits_data_coh_state, io_write_bits_data_tag);
        wpend = 1'b0;
      end
      @(negedge clock);
    end
    io_write_valid = 1'b0;
    io_read_valid  = 1'b0;
    checks++; if (io_resp_valid !== exp_rv || (exp_rv && (io_resp_bits_coh_state !== ec || io_resp_bits_tag !== et))) begin errors++; $display("[TB] FAIL rand_last: got v=%0b coh=%h tag=%h exp v=%0b coh=%h tag=%h", io_resp_valid, io_resp_bits_coh_state, io_resp_bits_tag, exp_rv, ec, et); end
    @(negedge clock);
  endtask

  task automatic test_mid_reset();
    int   cycles;
    logic bad;
    int   sets [6] = '{9, 5, 63, 1, 2, 3};
    do_write(9, 8'hFF, 2'd3, 21'h0F0F0F);
    do_read(9);
    checks++; if (io_resp_valid !== 1'b1) begin errors++; $display("[TB] FAIL mid_rv_before: got %0b exp 1", io_resp_valid); end
    #2;
    reset = 1'b0;
    #1;
    checks++; if (io_resp_valid !== 1'b0 || io_init_done !== 1'b0) begin errors++; $display("[TB] FAIL mid_async: got rv=%0b done=%0b exp 0/0", io_resp_valid, io_init_done); end
    checks++; if (io_read_ready !== 1'b0 || io_write_ready !== 1'b0) begin errors++; $display("[TB] FAIL mid_ready: got rd=%0b wr=%0b exp 0/0", io_read_ready, io_write_ready); end
    repeat (2) @(negedge clock);
    reset = 1'b1;
    wait_init(cycles, bad);
    checks++; if (cycles != 64) begin errors++; $display("[TB] FAIL mid_init_cycles: got %0d exp 64", cycles); end
    checks++; if (bad !== 1'b0) begin errors++; $display("[TB] FAIL mid_ready_early: got %0b exp 0", bad); end
    model_clear();
    for (int i = 0; i < 6; i++) begin
      do_read(sets[i]);
      checks++; if (io_resp_valid !== 1'b1 || io_resp_bits_coh_state !== exp_coh(sets[i]) || io_resp_bits_tag !== exp_tag(sets[i])) begin errors++; $display("[TB] FAIL mid_cleared set %0d: got v=%0b coh=%h tag=%h exp v=1 coh=0 tag=0", sets[i], io_resp_valid, io_resp_bits_coh_state, io_resp_bits_tag); end
    end
  endtask

  initial begin
    reset                        = 1'b0;
    io_write_valid               = 1'b0;
    io_write_bits_idx            = '0;
    io_write_bits_way_en         = '0;
    io_write_bits_data_coh_state = '0;
    io_write_bits_data_tag       = '0;
    io_read_valid                = 1'b0;
    io_read_bits_idx             = '0;
    test_reset();
    test_single_write();
    test_collision();
    test_masks();
    test_back_to_back();
    test_random();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
